// File: rtl/fwd_hazard_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : fwd_hazard_pkg
// Purpose  : Shared types and constants for the forwarding / hazard controller.
//            Holds the controller state encoding, the forwarding-select width
//            helper and the "read from register file" select code.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fwd_hazard_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Select code meaning "no forwarding, use the register file value".
  localparam int FWD_REGFILE = 0;

  // Width of the remaining-bubble counter; bubble counts run 1..15.
  localparam int LU_CNT_W = 4;

  // Width of one per-source select: codes 0..num_fwd.
  function automatic int sel_w(input int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_hazard_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : fwd_hazard_ctrl_if
// Purpose  : Bundles the pipeline-side signals seen by the forwarding / hazard
//            controller.
// Ports    : master - pipeline side (drives register ids and status, receives
//                     operand selects and stall controls)
//            slave  - controller side (the reverse)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fwd_hazard_ctrl_if
  import fwd_hazard_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
);

  localparam int SEL_W = sel_w(NUM_FWD);

  logic [NUM_SRC*REG_W-1:0] ex_rs;
  logic [NUM_SRC*REG_W-1:0] id_rs;
  logic                     id_valid;
  logic [REG_W-1:0]         ex_rd;
  logic                     ex_regwrite;
  logic                     ex_is_load;
  logic [NUM_FWD*REG_W-1:0] stage_rd;
  logic [NUM_FWD-1:0]       stage_regwrite;
  logic                     mem_busy;
  logic                     flush;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     stall_id;
  logic                     bubble_ex;
  logic                     freeze;
  logic [CNT_W-1:0]         stall_cycles;

  modport master (
    output ex_rs, id_rs, id_valid, ex_rd, ex_regwrite, ex_is_load,
           stage_rd, stage_regwrite, mem_busy, flush,
    input  fwd_sel, stall_id, bubble_ex, freeze, stall_cycles
  );

  modport slave (
    input  ex_rs, id_rs, id_valid, ex_rd, ex_regwrite, ex_is_load,
           stage_rd, stage_regwrite, mem_busy, flush,
    output fwd_sel, stall_id, bubble_ex, freeze, stall_cycles
  );

endinterface

`default_nettype wire

// File: rtl/fwd_hazard_ctrl_select.sv
//------------------------------------------------------------------------------
// Module   : fwd_select
// Purpose  : Priority encoder for one EX source operand. Picks the nearest
//            producer stage that writes the same non-zero register.
// Ports    : rs             in  source register id
//            stage_rd       in  producer destination ids (stage 0 nearest)
//            stage_regwrite in  producer write enables
//            sel            out 0 = register file, k = stage k-1
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fwd_select
  import fwd_hazard_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = sel_w(NUM_FWD)
) (
  input  wire logic [REG_W-1:0]         rs,
  input  wire logic [NUM_FWD*REG_W-1:0] stage_rd,
  input  wire logic [NUM_FWD-1:0]       stage_regwrite,
  output logic      [SEL_W-1:0]         sel
);

  logic [NUM_FWD-1:0] w_match;

  for (genvar k = 0; k < NUM_FWD; k++) begin : g_match
    // x0 is hard-wired to zero and must never be forwarded.
    assign w_match[k] = stage_regwrite[k]
                      && (stage_rd[k*REG_W +: REG_W] != '0)
                      && (stage_rd[k*REG_W +: REG_W] == rs);
  end

  // Scan from the farthest stage down so the nearest match is written last.
  always_comb begin
    sel = SEL_W'(FWD_REGFILE);
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module   : fwd_hazard_ctrl
// Purpose  : Forwarding and hazard controller at the ID/EX boundary. Drives
//            the EX operand selects, load-use stall/bubble controls, the
//            memory-wait freeze, and a saturating stall-cycle counter.
// Ports    : clk  in  clock
//            rst  in  synchronous active-high reset
//            bus  slave modport of fwd_hazard_ctrl_if (register ids, status,
//                 fwd_sel, stall_id, bubble_ex, freeze, stall_cycles)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fwd_hazard_ctrl
  import fwd_hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_FWD    = 2,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input wire logic         clk,
  input wire logic         rst,
  fwd_hazard_ctrl_if.slave bus
);

  localparam int                  SEL_W    = sel_w(NUM_FWD);
  localparam logic [LU_CNT_W-1:0] C_RELOAD = LU_CNT_W'(LU_BUBBLES - 1);
  localparam bit                  C_MULTI  = (LU_BUBBLES > 1);

  // ---------------- forwarding ----------------
  logic [SEL_W-1:0]         w_sel [NUM_SRC];
  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    fwd_select #(
      .REG_W   (REG_W),
      .NUM_FWD (NUM_FWD),
      .SEL_W   (SEL_W)
    ) u_sel (
      .rs             (bus.ex_rs[j*REG_W +: REG_W]),
      .stage_rd       (bus.stage_rd),
      .stage_regwrite (bus.stage_regwrite),
      .sel            (w_sel[j])
    );
  end

  always_comb begin
    w_fwd_sel = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      w_fwd_sel[j*SEL_W +: SEL_W] = w_sel[j];
    end
  end

  assign bus.fwd_sel = rst ? '0 : w_fwd_sel;

  // ---------------- load-use detect ----------------
  logic w_rs_hit;
  logic w_lu_hit;

  always_comb begin
    w_rs_hit = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (bus.id_rs[j*REG_W +: REG_W] == bus.ex_rd) begin
        w_rs_hit = 1'b1;
      end
    end
  end

  assign w_lu_hit = bus.ex_is_load && bus.ex_regwrite && (bus.ex_rd != '0)
                  && bus.id_valid && w_rs_hit;

  // ---------------- stall / freeze control ----------------
  state_t              r_state;
  state_t              r_ret_state;
  logic [LU_CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0]    r_stall_cycles;

  state_t              w_eff_state;
  state_t              w_nxt_state;
  state_t              w_nxt_ret;
  logic [LU_CNT_W-1:0] w_nxt_cnt;
  logic                w_stall;
  logic                w_bubble;
  logic                w_freeze;

  always_comb begin
    // The cycle mem_busy drops is already evaluated with the rules of the
    // state we return to, so the pipeline resumes without a dead cycle.
    w_eff_state = ((r_state == MEM_WAIT) && !bus.mem_busy) ? r_ret_state : r_state;
    w_nxt_state = w_eff_state;
    w_nxt_ret   = r_ret_state;
    w_nxt_cnt   = r_cnt;
    w_stall     = 1'b0;
    w_bubble    = 1'b0;
    w_freeze    = 1'b0;

    if (bus.mem_busy) begin
      w_freeze    = 1'b1;
      w_nxt_state = MEM_WAIT;
      if (r_state != MEM_WAIT) begin
        w_nxt_ret = r_state;
      end
    end else begin
      case (w_eff_state)
        RUN: begin
          // A flush kills the ID instruction, so its hazard is moot.
          if (!bus.flush && w_lu_hit) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            if (C_MULTI) begin
              w_nxt_state = LU_STALL;
              w_nxt_cnt   = C_RELOAD;
            end
          end
        end
        LU_STALL: begin
          if (bus.flush) begin
            w_nxt_state = RUN;
            w_nxt_cnt   = '0;
          end else begin
            w_stall   = 1'b1;
            w_bubble  = 1'b1;
            w_nxt_cnt = r_cnt - LU_CNT_W'(1);
            // <= also recovers from a zero count rather than wrapping.
            if (r_cnt <= LU_CNT_W'(1)) begin
              w_nxt_state = RUN;
            end
          end
        end
        default: begin
          w_nxt_state = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_ret_state    <= RUN;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_ret_state <= w_nxt_ret;
      r_cnt       <= w_nxt_cnt;
      if ((w_stall || w_freeze) && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

  assign bus.stall_id     = w_stall  && !rst;
  assign bus.bubble_ex    = w_bubble && !rst;
  assign bus.freeze       = w_freeze && !rst;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire
